// File: rtl/t05_header_synth.sv
// Serialises codebook entries (flag, char index, path length, path bits) to an SPI bit writer,
// followed by a single 0 end-marker bit once the codebook traversal is finished.
module t05_header_synth #(
    parameter int PATH_W = 128,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_found,
    input  logic [7:0]        char_index,
    input  logic [PATH_W-1:0] char_path,
    input  logic              cb_done,
    input  logic              bit_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              write_finish,
    output logic              busy,
    output logic              header_done,
    output logic              overrun
);

    typedef enum logic [3:0] {
        IDLE, LOAD, FLAG, IDX, LEN, PATH, ACK, ENDBIT, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [PATH_W-1:0]   path_q, path_d;
    logic                cbl_q, cbl_d;
    logic                bit_out_q, bit_out_d;
    logic                bit_valid_q, bit_valid_d;
    logic                write_finish_q, write_finish_d;
    logic                busy_q, busy_d;
    logic                header_done_q, header_done_d;
    logic                overrun_q, overrun_d;
    logic                xfer;

    // Position of the control bit; an all-zero word yields 0.
    function automatic logic [LEN_W-1:0] msb_pos(input logic [PATH_W-1:0] p);
        msb_pos = '0;
        for (int i = 0; i < PATH_W; i++)
            if (p[i]) msb_pos = LEN_W'(i);
    endfunction

    function automatic logic sel_bit(input state_t st, input logic [LEN_W-1:0] cnt,
                                     input logic [7:0] idx, input logic [LEN_W-1:0] len,
                                     input logic [PATH_W-1:0] path);
        logic [7:0]        ti;
        logic [LEN_W-1:0]  tl;
        logic [PATH_W-1:0] tp;
        ti = idx >> (LEN_W'(7) - cnt);
        tl = len >> (LEN_W'(LEN_W - 1) - cnt);
        tp = path >> (len - cnt - LEN_W'(1));
        case (st)
            FLAG:    sel_bit = 1'b1;
            IDX:     sel_bit = ti[0];
            LEN:     sel_bit = tl[0];
            PATH:    sel_bit = tp[0];
            default: sel_bit = 1'b0;
        endcase
    endfunction

    assign xfer = bit_valid_q & bit_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        len_d         = len_q;
        path_d        = path_q;
        cbl_d         = cbl_q | (cb_done && state_q != IDLE);
        overrun_d     = overrun_q | (char_found && state_q != IDLE);
        header_done_d = header_done_q;
        case (state_q)
            IDLE: begin
                if (char_found) begin
                    idx_d   = char_index;
                    path_d  = char_path;
                    len_d   = msb_pos(char_path);
                    cnt_d   = '0;
                    state_d = LOAD;
                    if (char_path == '0) overrun_d = 1'b1;
                    if (cb_done) cbl_d = 1'b1;
                end else if (cb_done || cbl_q) begin
                    cbl_d   = 1'b0;
                    state_d = ENDBIT;
                end
            end
            LOAD: state_d = FLAG;
            FLAG: if (xfer) begin
                state_d = IDX;
                cnt_d   = '0;
            end
            IDX: if (xfer) begin
                if (cnt_q == LEN_W'(7)) begin
                    state_d = LEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            LEN: if (xfer) begin
                if (cnt_q == LEN_W'(LEN_W - 1)) begin
                    state_d = (len_q == '0) ? ACK : PATH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            PATH: if (xfer) begin
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            ACK:    state_d = IDLE;
            ENDBIT: if (xfer) begin
                state_d       = DONE;
                header_done_d = 1'b1;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state, so bit_out holds while stalled.
        bit_valid_d    = (state_d == FLAG) || (state_d == IDX) || (state_d == LEN) ||
                         (state_d == PATH) || (state_d == ENDBIT);
        busy_d         = (state_d == LOAD) || (state_d == FLAG) || (state_d == IDX) ||
                         (state_d == LEN)  || (state_d == PATH);
        write_finish_d = (state_d == ACK);
        bit_out_d      = bit_valid_d ? sel_bit(state_d, cnt_d, idx_d, len_d, path_d) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            len_q          <= '0;
            path_q         <= '0;
            cbl_q          <= 1'b0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            write_finish_q <= 1'b0;
            busy_q         <= 1'b0;
            header_done_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            path_q         <= path_d;
            cbl_q          <= cbl_d;
            bit_out_q      <= bit_out_d;
            bit_valid_q    <= bit_valid_d;
            write_finish_q <= write_finish_d;
            busy_q         <= busy_d;
            header_done_q  <= header_done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bit_out      = bit_out_q;
    assign bit_valid    = bit_valid_q;
    assign write_finish = write_finish_q;
    assign busy         = busy_q;
    assign header_done  = header_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_t05_header_synth.sv
// Bench for t05_header_synth: table-driven entries, directed corner sequences and
// randomized entries compared against a bit-list model of the header format.
module tb_t05_header_synth;

    localparam int PATH_W = 128;
    localparam int LEN_W  = 7;

    logic              clk = 0;
    logic              rst = 0;
    logic              char_found = 0;
    logic [7:0]        char_index = '0;
    logic [PATH_W-1:0] char_path = '0;
    logic              cb_done = 0;
    logic              bit_ready = 0;
    logic              bit_out, bit_valid, write_finish, busy, header_done, overrun;

    t05_header_synth #(.PATH_W(PATH_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .char_found(char_found), .char_index(char_index),
        .char_path(char_path), .cb_done(cb_done), .bit_ready(bit_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .write_finish(write_finish),
        .busy(busy), .header_done(header_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1);
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [255:0] got_bits, exp_bits;
    int           got_n, exp_n, exp_l;

    typedef struct {
        logic [7:0]        idx;
        logic [PATH_W-1:0] path;
        int                mode;
        int                nbits;
        int                lat;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: the entry as an ordered list of bits, packed first-bit-most-significant.
    task automatic model(input logic [7:0] idx, input logic [PATH_W-1:0] path);
        exp_l = 0;
        for (int i = 0; i < PATH_W; i++) if (path[i]) exp_l = i;
        exp_bits = '0;
        exp_n = 0;
        exp_bits = {exp_bits[254:0], 1'b1}; exp_n++;
        for (int i = 7; i >= 0; i--) begin exp_bits = {exp_bits[254:0], idx[i]}; exp_n++; end
        for (int i = LEN_W - 1; i >= 0; i--) begin
            exp_bits = {exp_bits[254:0], 1'((exp_l >> i) & 1)}; exp_n++;
        end
        for (int i = exp_l - 1; i >= 0; i--) begin exp_bits = {exp_bits[254:0], path[i]}; exp_n++; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; char_found = 0; cb_done = 0; bit_ready = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic send_entry(input logic [7:0] idx, input logic [PATH_W-1:0] path, input int mode,
                              input int inj_cf, input int inj_cb, output int lat);
        int n; bit fin; bit stall_prev; logic prev_bit; int stall_err; logic rdy;
        got_bits = '0; got_n = 0; lat = -1; stall_err = 0; stall_prev = 0; prev_bit = 0;
        @(posedge clk); #1;
        char_index = idx; char_path = path; char_found = 1; cb_done = (inj_cb == 0); bit_ready = 1;
        @(posedge clk); #1;
        char_found = 0; cb_done = 0; char_index = ~idx; char_path = ~path;
        chk("load_no_valid", bit_valid, 0);
        chk("load_busy", busy, 1);
        n = 1; fin = 0;
        while (!fin && n < 2000) begin
            if (write_finish) begin
                fin = 1; lat = n;
                chk("ack_busy_low", busy, 0);
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((n - 1) % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bit_ready  = rdy;
                char_found = (n == inj_cf);
                cb_done    = (n == inj_cb);
                if (bit_valid && stall_prev && bit_out !== prev_bit) stall_err++;
                if (bit_valid && rdy) begin got_bits = {got_bits[254:0], bit_out}; got_n++; end
                stall_prev = bit_valid && !rdy;
                prev_bit   = bit_out;
                @(posedge clk); #1;
                n++;
            end
        end
        char_found = 0; cb_done = 0;
        chk("write_finish_seen", fin, 1);
        chk("stall_hold", stall_err, 0);
    endtask

    task automatic verify(input string tag, input logic [7:0] idx, input logic [PATH_W-1:0] path,
                          input int mode, input int inj_cf, input int inj_cb);
        int lat;
        model(idx, path);
        send_entry(idx, path, mode, inj_cf, inj_cb, lat);
        chk({tag, "_nbits"}, got_n, exp_n);
        chk({tag, "_bits"}, got_bits, exp_bits);
        if (mode == 0) chk({tag, "_latency"}, lat, 2 + 1 + 8 + LEN_W + exp_l);
    endtask

    task automatic check_endmarker();
        int n = 0;
        bit_ready = 1;
        @(posedge clk); #1;
        while (!bit_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("endbit_valid", bit_valid, 1);
        chk("endbit_value", bit_out, 0);
        chk("endbit_not_done_yet", header_done, 0);
        @(posedge clk); #1;
        chk("header_done_set", header_done, 1);
        chk("done_valid_low", bit_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_absorbing", {bit_valid, header_done}, 2'b01);
    endtask

    initial begin
        int lat, wf_cnt, k;
        logic [PATH_W-1:0] r, mask, p;

        vecs[0] = '{8'h41, 128'b1011, 0, 19, 21};
        vecs[1] = '{8'h00, 128'b1,    0, 16, 18};
        vecs[2] = '{8'h41, 128'b1011, 1, 19, -1};
        vecs[3] = '{8'hFF, {1'b1, 127'h5A5A_0F0F_3C3C_FFFF_0000_1234_8001_7FF}, 0, 143, 145};
        vecs[4] = '{8'h80, 128'b110, 2, 18, -1};

        do_reset();
        chk("rst_bit_out", bit_out, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_write_finish", write_finish, 0);
        chk("rst_busy", busy, 0);
        chk("rst_header_done", header_done, 0);
        chk("rst_overrun", overrun, 0);

        for (int i = 0; i < 5; i++) begin
            model(vecs[i].idx, vecs[i].path);
            send_entry(vecs[i].idx, vecs[i].path, vecs[i].mode, -1, -1, lat);
            chk($sformatf("vec%0d_nbits", i), got_n, vecs[i].nbits);
            chk($sformatf("vec%0d_bits", i), got_bits, exp_bits);
            if (vecs[i].lat >= 0) chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            if (i == 0) chk("vec0_literal", got_bits, 256'b1_01000001_0000011_011);
            if (i == 1) chk("vec1_literal", got_bits, 256'b1_00000000_0000000);
        end
        chk("no_overrun_clean", overrun, 0);

        // char_found during IDX is ignored and flagged
        do_reset();
        verify("ovr_idx", 8'h41, 128'b1011, 0, 5, -1);
        chk("ovr_idx_overrun", overrun, 1);
        @(posedge clk); #1;
        chk("ovr_idx_no_restart", busy, 0);

        // cb_done during PATH: end marker after the entry
        do_reset();
        verify("cb_path", 8'h41, 128'b1011, 0, -1, 19);
        check_endmarker();
        chk("cb_path_no_overrun", overrun, 0);
        @(posedge clk); #1;
        char_found = 1; char_path = 128'b11;
        @(posedge clk); #1;
        char_found = 0;
        chk("done_char_found_overrun", overrun, 1);
        chk("done_stays_idle", {busy, bit_valid}, 2'b00);

        // char_found and cb_done together: entry first, then end marker
        do_reset();
        verify("cf_cb_same", 8'h5C, 128'b1_0110, 1, -1, 0);
        check_endmarker();

        // reset in LEN aborts the entry
        do_reset();
        @(posedge clk); #1;
        char_index = 8'h41; char_path = 128'b1011; char_found = 1; bit_ready = 1;
        @(posedge clk); #1;
        char_found = 0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_outputs",
            {bit_out, bit_valid, write_finish, busy, header_done, overrun}, 6'b0);
        wf_cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (write_finish || bit_valid) wf_cnt++;
        end
        chk("midrst_no_resume", wf_cnt, 0);
        verify("after_rst", 8'h42, 128'b10, 0, -1, -1);
        chk("after_rst_literal", got_bits, 256'b1_01000010_0000001_0);

        // char_path = 0: L = 0 and overrun
        do_reset();
        verify("zero_path", 8'h33, 128'b0, 0, -1, -1);
        chk("zero_path_overrun", overrun, 1);

        // randomized entries
        do_reset();
        for (int t = 0; t < 20; t++) begin
            k = $urandom_range(0, PATH_W - 1);
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            mask = (128'b1 << k) - 128'b1;
            p = (r & mask) | (128'b1 << k);
            verify($sformatf("rand%0d", t), 8'($urandom()), p, $urandom_range(0, 2), -1, -1);
        end
        chk("rand_no_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
